fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard unit for the 5-stage RISC-V pipeline. It replaces the purely combinational EX-stage forwarding decode with three functions: a registered decode computed in ID, a multi-cycle load-use stall FSM, and an ID-stage write-back bypass. Generalised to NUM_SRC source operands and a configurable load-use bubble count. It also provides a saturating stall performance counter.

Parameters:
REG_AW, 5, register address width (x0 = address 0, never forwarded, never stalls)
NUM_SRC, 2, number of source operands per instruction
STALL_CYC, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs  in  NUM_SRC*REG_AW  ID-stage source addresses, operand i at [i*REG_AW +: REG_AW]
id_rs_used  in  NUM_SRC  operand i actually read by the ID instruction
idex_rd  in  REG_AW  ID/EX destination
idex_reg_write  in  1  ID/EX writes rd
idex_mem_read  in  1  ID/EX is a load
exmem_rd  in  REG_AW  EX/MEM destination
exmem_reg_write  in  1  EX/MEM writes rd
memwb_rd  in  REG_AW  MEM/WB destination
memwb_reg_write  in  1  MEM/WB writes rd
flush  in  1  branch/jump flush of IF/ID and ID/EX this cycle
fwd_sel  out  2*NUM_SRC  registered EX operand select, operand i at [2i+:2]: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 unused
id_wb_bypass  out  NUM_SRC  combinational: ID must take the WB value for operand i
stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
stall_count  out  CNT_W  total stall cycles, saturating

Behaviour:
- Reset (async, rst=1): fwd_sel=0, stall_cnt=0, state=IDLE, stall_count=0. While rst=1, stall=0.
- Match rule, per operand i: m_X(i) = X_reg_write & X_rd!=0 & X_rd==id_rs[i].
- Load-use hazard: haz = any i with id_rs_used[i] & m_idex(i) & idex_mem_read.
- Next-cycle select per operand i:
  - m_idex(i) & !idex_mem_read -> 10
  - else m_exmem(i) -> 01
  - else 00
  - The ID/EX match has priority over EX/MEM (youngest producer wins).
- fwd_sel register update each edge:
  - flush=1 or stall=1 -> 0 (a bubble or a killed instruction enters EX).
  - Otherwise -> the computed selects.
  - Latency: decoded in the ID cycle, valid for the whole cycle that instruction spends in EX.
- id_wb_bypass[i] = m_memwb(i) (combinational, same cycle). It covers the regfile write/read collision in ID.
- Stall FSM, states IDLE and STALL, with counter stall_cnt (3 bits):
  - IDLE: stall = haz & !flush. On stall with STALL_CYC>1, go to STALL and load stall_cnt = STALL_CYC-1. With STALL_CYC=1, remain in IDLE.
  - STALL: stall = !flush. stall_cnt decrements each edge; return to IDLE when stall_cnt reaches 1 at the edge.
  - A new haz in STALL does not restart the count. ID/EX holds bubbles, so haz cannot recur during STALL.
  - flush in any state: stall=0 that cycle, next state IDLE, stall_cnt=0.
- stall_count increments by 1 on every edge where stall=1 and saturates at 2^CNT_W-1.
- id_rs_used=0 for an operand suppresses the stall for that operand only. Forwarding for that operand is still computed and is harmless.
- Reset mid-stall: stall drops immediately; FSM returns to IDLE.

Test Plan:
- Forward from EX/MEM: idex_rd=5, idex_reg_write=1, idex_mem_read=0, id_rs0=5 -> stall=0; after the edge, fwd_sel[1:0]=10.
- Load-use, STALL_CYC=1: idex_mem_read=1, idex_rd=7, id_rs1=7, id_rs_used=2'b10 -> cycle0 stall=1. Cycle1: bubble in ID/EX, exmem_rd=7 -> stall=0, fwd_sel=00. Cycle2: fwd_sel[3:2]=01. stall_count=1.
- x0 and priority:
  - rd=0 with every write enable set -> fwd_sel=00, stall=0.
  - idex_rd=exmem_rd=3, both writing, id_rs0=3 -> fwd_sel[1:0]=10.
- WB bypass: memwb_rd=9, memwb_reg_write=1, id_rs0=9 -> id_wb_bypass[0]=1 in the same cycle, no stall. With memwb_reg_write=0 -> 0.
- STALL_CYC=3: a load-use hazard gives stall=1 for 3 consecutive cycles and stall_count+3. Repeat with flush=1 in the 2nd stall cycle -> stall=0 that cycle, IDLE next, fwd_sel=0, stall_count+1 total.
- Async reset asserted mid-stall between edges -> stall, fwd_sel and stall_count go to 0 immediately. After release, a saturated stall_count test (CNT_W=4, 20 stalls) reads 15.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the 5-stage pipeline.
// The EX operand selects are decoded while the instruction is still in ID and
// registered, so they are stable for the whole EX cycle. Load-use hazards are
// resolved by a small stall FSM that can insert several bubbles. Same-cycle
// regfile write/read collisions in ID are covered by a write-back bypass flag.
// A saturating counter records how many cycles the pipeline spent stalled.
module fwd_hazard_unit #(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int STALL_CYC = 1,
    parameter int CNT_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]          id_rs_used,
    input  logic [REG_AW-1:0]           idex_rd,
    input  logic                        idex_reg_write,
    input  logic                        idex_mem_read,
    input  logic [REG_AW-1:0]           exmem_rd,
    input  logic                        exmem_reg_write,
    input  logic [REG_AW-1:0]           memwb_rd,
    input  logic                        memwb_reg_write,
    input  logic                        flush,
    output logic [2*NUM_SRC-1:0]        fwd_sel,
    output logic [NUM_SRC-1:0]          id_wb_bypass,
    output logic                        stall,
    output logic [CNT_W-1:0]            stall_count
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_STALL = 1'b1;

    // A single bubble never needs the STALL state; longer hazards park there.
    localparam bit         MULTI_CYC  = (STALL_CYC > 1);
    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYC - 1);

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_EXMEM   = 2'b10;
    localparam logic [1:0] SEL_MEMWB   = 2'b01;

    logic                   state;
    logic [2:0]             stall_cnt;
    logic [NUM_SRC-1:0]     m_idex;
    logic [NUM_SRC-1:0]     m_exmem;
    logic [NUM_SRC-1:0]     m_memwb;
    logic                   haz;
    logic [2*NUM_SRC-1:0]   sel_next;

    // Per-operand producer matching and next-cycle EX select decode.
    always_comb begin
        m_idex   = '0;
        m_exmem  = '0;
        m_memwb  = '0;
        sel_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            m_idex[i]  = idex_reg_write  && (idex_rd  != '0) &&
                         (idex_rd  == id_rs[i*REG_AW +: REG_AW]);
            m_exmem[i] = exmem_reg_write && (exmem_rd != '0) &&
                         (exmem_rd == id_rs[i*REG_AW +: REG_AW]);
            m_memwb[i] = memwb_reg_write && (memwb_rd != '0) &&
                         (memwb_rd == id_rs[i*REG_AW +: REG_AW]);
            if (m_idex[i] && !idex_mem_read) begin
                sel_next[2*i +: 2] = SEL_EXMEM;
            end else if (m_exmem[i]) begin
                sel_next[2*i +: 2] = SEL_MEMWB;
            end else begin
                sel_next[2*i +: 2] = SEL_REGFILE;
            end
        end
        haz          = (|(id_rs_used & m_idex)) && idex_mem_read;
        id_wb_bypass = m_memwb;
    end

    // Stall request: flush and reset always win, STALL holds regardless of haz.
    always_comb begin
        stall = 1'b0;
        if (rst || flush) begin
            stall = 1'b0;
        end else if (state == ST_STALL) begin
            stall = 1'b1;
        end else begin
            stall = haz;
        end
    end

    // Stall FSM: count down the remaining bubbles of a multi-cycle load-use stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            stall_cnt <= 3'd0;
        end else if (flush) begin
            state     <= ST_IDLE;
            stall_cnt <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (haz && MULTI_CYC) begin
                        state     <= ST_STALL;
                        stall_cnt <= STALL_LOAD;
                    end
                end
                ST_STALL: begin
                    if (stall_cnt <= 3'd1) begin
                        state     <= ST_IDLE;
                        stall_cnt <= 3'd0;
                    end else begin
                        stall_cnt <= stall_cnt - 3'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    stall_cnt <= 3'd0;
                end
            endcase
        end
    end

    // EX operand select register; bubbles and killed instructions get regfile selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_sel <= '0;
        end else if (flush || stall) begin
            fwd_sel <= '0;
        end else begin
            fwd_sel <= sel_next;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit. Two instances share the inputs:
// dut_a uses a single load-use bubble and a 32-bit counter, dut_b uses three
// bubbles and a 4-bit counter so saturation is reachable.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  idex_rd;
    logic        idex_reg_write;
    logic        idex_mem_read;
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write;
    logic [4:0]  memwb_rd;
    logic        memwb_reg_write;
    logic        flush;

    logic [3:0]  fwd_a;
    logic [1:0]  byp_a;
    logic        stall_a;
    logic [31:0] cnt_a;
    logic [3:0]  fwd_b;
    logic [1:0]  byp_b;
    logic        stall_b;
    logic [3:0]  cnt_b;

    int tests    = 0;
    int failures = 0;

    // Reference model state: remaining forced stall cycles, expected registers.
    int          rem_a, rem_b;
    logic [3:0]  m_fwd_a, m_fwd_b;
    longint      m_cnt_a, m_cnt_b;

    localparam int STALL_A = 1;
    localparam int STALL_B = 3;

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .STALL_CYC(STALL_A), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .idex_rd(idex_rd), .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .flush(flush),
        .fwd_sel(fwd_a), .id_wb_bypass(byp_a), .stall(stall_a), .stall_count(cnt_a)
    );

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .STALL_CYC(STALL_B), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .idex_rd(idex_rd), .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .flush(flush),
        .fwd_sel(fwd_b), .id_wb_bypass(byp_b), .stall(stall_b), .stall_count(cnt_b)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout reached before the end of the sequence");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [4:0] rs_of(input int i);
        logic [9:0] v;
        v = id_rs;
        return v[i*5 +: 5];
    endfunction

    // True when the given producer writes operand i's register (x0 excluded).
    function automatic bit writes(input logic we, input logic [4:0] rd, input int i);
        return we && (rd != 5'd0) && (rd == rs_of(i));
    endfunction

    // Where EX must fetch operand i next cycle: the instruction now in ID/EX
    // (unless it is a load), else the one in EX/MEM, else the register file.
    function automatic logic [1:0] src_of(input int i);
        if (writes(idex_reg_write, idex_rd, i) && !idex_mem_read) return 2'b10;
        if (writes(exmem_reg_write, exmem_rd, i)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit load_use();
        bit h;
        h = 1'b0;
        for (int i = 0; i < 2; i++)
            if (id_rs_used[i] && idex_mem_read && writes(idex_reg_write, idex_rd, i)) h = 1'b1;
        return h;
    endfunction

    function automatic logic [1:0] bypass_exp();
        return {writes(memwb_reg_write, memwb_rd, 1) ? 1'b1 : 1'b0,
                writes(memwb_reg_write, memwb_rd, 0) ? 1'b1 : 1'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                                 input logic [4:0] i_rd, input logic i_we, input logic i_ld,
                                 input logic [4:0] e_rd, input logic e_we,
                                 input logic [4:0] w_rd, input logic w_we, input logic fl);
        id_rs           = {rs1, rs0};
        id_rs_used      = used;
        idex_rd         = i_rd;
        idex_reg_write  = i_we;
        idex_mem_read   = i_ld;
        exmem_rd        = e_rd;
        exmem_reg_write = e_we;
        memwb_rd        = w_rd;
        memwb_reg_write = w_we;
        flush           = fl;
    endtask

    task automatic model_reset();
        rem_a = 0; rem_b = 0;
        m_fwd_a = '0; m_fwd_b = '0;
        m_cnt_a = 0; m_cnt_b = 0;
    endtask

    // One clock cycle: compare every output at the negedge, then advance the model.
    task automatic runCycle();
        logic       ea, eb, h;
        logic [3:0] sel;
        @(negedge clk);
        h   = load_use();
        sel = {src_of(1), src_of(0)};
        ea  = !flush && ((rem_a > 0) || h);
        eb  = !flush && ((rem_b > 0) || h);
        checkOutput("stall_a", stall_a, ea);
        checkOutput("stall_b", stall_b, eb);
        checkOutput("bypass_a", byp_a, bypass_exp());
        checkOutput("bypass_b", byp_b, bypass_exp());
        checkOutput("fwd_a", fwd_a, m_fwd_a);
        checkOutput("fwd_b", fwd_b, m_fwd_b);
        checkOutput("count_a", cnt_a, m_cnt_a[31:0]);
        checkOutput("count_b", cnt_b, m_cnt_b[31:0]);
        @(posedge clk);
        m_fwd_a = (flush || ea) ? 4'b0 : sel;
        m_fwd_b = (flush || eb) ? 4'b0 : sel;
        if (ea && m_cnt_a < 64'hFFFF_FFFF) m_cnt_a++;
        if (eb && m_cnt_b < 15) m_cnt_b++;
        if (flush)          rem_a = 0;
        else if (rem_a > 0) rem_a--;
        else if (h)         rem_a = STALL_A - 1;
        if (flush)          rem_b = 0;
        else if (rem_b > 0) rem_b--;
        else if (h)         rem_b = STALL_B - 1;
        #1;
    endtask

    initial begin
        logic [31:0] ca0;
        logic [3:0]  cb0, diff;

        $display("[TB] start");
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        checkOutput("reset_stall_a", stall_a, 0);
        checkOutput("reset_fwd_a", fwd_a, 0);
        checkOutput("reset_count_b", cnt_b, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Forward from EX/MEM
        applyStimulus(5, 0, 2'b01, 5, 1, 0, 0, 0, 0, 0, 0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("fwd_exmem", fwd_a[1:0], 2'b10);
        runCycle();

        // Load-use with one bubble
        ca0 = cnt_a;
        applyStimulus(0, 7, 2'b10, 7, 1, 1, 0, 0, 0, 0, 0);
        #1 checkOutput("lu_stall", stall_a, 1);
        runCycle();
        applyStimulus(0, 7, 2'b10, 0, 0, 0, 7, 1, 0, 0, 0);
        #1 checkOutput("lu_release", stall_a, 0);
        checkOutput("lu_bubble_fwd", fwd_a, 0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lu_fwd_memwb", fwd_a[3:2], 2'b01);
        checkOutput("lu_count", cnt_a - ca0, 1);
        runCycle(); runCycle(); runCycle();

        // x0 is never forwarded and never stalls
        applyStimulus(0, 0, 2'b11, 0, 1, 1, 0, 1, 0, 1, 0);
        #1 checkOutput("x0_stall_b", stall_b, 0);
        runCycle();
        checkOutput("x0_fwd", fwd_a, 0);
        // Youngest producer wins
        applyStimulus(3, 0, 2'b01, 3, 1, 0, 3, 1, 0, 0, 0);
        runCycle();
        checkOutput("prio_fwd", fwd_a[1:0], 2'b10);

        // Write-back bypass in ID
        applyStimulus(9, 0, 2'b01, 0, 0, 0, 0, 0, 9, 1, 0);
        #1 checkOutput("wb_bypass_on", byp_a[0], 1);
        runCycle();
        applyStimulus(9, 0, 2'b01, 0, 0, 0, 0, 0, 9, 0, 0);
        #1 checkOutput("wb_bypass_off", byp_a[0], 0);
        runCycle();

        // Three-bubble stall
        cb0 = cnt_b;
        applyStimulus(7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle(); runCycle(); runCycle();
        diff = cnt_b - cb0;
        checkOutput("stall3_count", diff, 3);

        // Three-bubble stall cut short by a flush in its second cycle
        cb0 = cnt_b;
        applyStimulus(7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 checkOutput("flush_stall", stall_b, 0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("flush_idle", stall_b, 0);
        checkOutput("flush_fwd", fwd_b, 0);
        runCycle();
        diff = cnt_b - cb0;
        checkOutput("flush_count", diff, 1);

        // Asynchronous reset between edges while dut_b is stalling
        applyStimulus(7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 0);
        runCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 checkOutput("pre_rst_stall", stall_b, 1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_stall_b", stall_b, 0);
        checkOutput("rst_fwd_a", fwd_a, 0);
        checkOutput("rst_fwd_b", fwd_b, 0);
        checkOutput("rst_count_a", cnt_a, 0);
        checkOutput("rst_count_b", cnt_b, 0);
        model_reset();
        applyStimulus(7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Saturation: twenty consecutive stalled cycles
        for (int k = 0; k < 20; k++) runCycle();
        checkOutput("sat_count_b", cnt_b, 15);
        checkOutput("sat_count_a", cnt_a, 20);

        // Randomised traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
            runCycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
